// File: rtl/desenha_pkg.sv
// -----------------------------------------------------------------------------
// desenha_pkg
// Shared constants for the sprite glyph renderer:
//   glyph_e      - glyph selection codes (blank, X, O, box)
//   COLOR_W      - width of the packed {R,G,B} colour word
//   PIPE_LATENCY - clock edges from a pixel's h_counter being sampled to its
//                  hit/R/G/B appearing on the outputs
// -----------------------------------------------------------------------------
package desenha_pkg;

    typedef enum logic [1:0] {
        GLYPH_BLANK = 2'd0,
        GLYPH_X     = 2'd1,
        GLYPH_O     = 2'd2,
        GLYPH_BOX   = 2'd3
    } glyph_e;

    localparam int COLOR_W      = 24;
    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/desenha_eixo.sv
// -----------------------------------------------------------------------------
// desenha_eixo
// One axis of the glyph raster walker.
// It is used twice: once for rows, stepped at each line start, and once for
// columns, stepped every pixel. The axis starts when the beam counter equals
// the start position. While active it repeats each source index `scale`
// times, then stops after GLYPH_SIZE*scale steps. The counters never wrap.
// Ports:
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   i_step       : advance/evaluate this axis on this cycle
//   i_clear      : deactivate (line or frame boundary) unless a start matches
//   i_counter    : beam counter for this axis (h or v)
//   i_start      : glyph start coordinate on this axis
//   i_scale      : integer scale, already forced to >= 1
//   o_idx        : current source index (row or column of the glyph)
//   o_act        : axis is inside the glyph
// -----------------------------------------------------------------------------
module desenha_eixo #(
    parameter int GLYPH_SIZE = 8,
    parameter int SCALE_W    = 4,
    parameter int CNT_W      = 10,
    parameter int IDX_W      = $clog2(GLYPH_SIZE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_step,
    input  logic               i_clear,
    input  logic [CNT_W-1:0]   i_counter,
    input  logic [CNT_W-1:0]   i_start,
    input  logic [SCALE_W-1:0] i_scale,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_act
);

    logic [IDX_W-1:0]   r_idx;
    logic [SCALE_W-1:0] r_sub;
    logic               r_act;
    logic               w_sub_last;
    logic               w_idx_last;

    assign w_sub_last = (r_sub == i_scale - 1'b1);
    assign w_idx_last = (r_idx == IDX_W'(GLYPH_SIZE - 1));

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_sub <= '0;
            r_act <= 1'b0;
        end else if (i_step) begin
            if (i_counter == i_start) begin
                r_idx <= '0;
                r_sub <= '0;
                r_act <= 1'b1;
            end else if (i_clear) begin
                // Leaving the line/frame truncates the glyph instead of wrapping it.
                r_act <= 1'b0;
            end else if (r_act) begin
                if (w_sub_last) begin
                    r_sub <= '0;
                    if (w_idx_last) r_act <= 1'b0;
                    else            r_idx <= r_idx + 1'b1;
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end
        end
    end

    assign o_idx = r_idx;
    assign o_act = r_act;

endmodule

// File: rtl/desenha_sprite.sv
// -----------------------------------------------------------------------------
// desenha_sprite
// Renders one procedurally generated glyph (blank, X, O, box) at a runtime
// position, integer scale and 24-bit colour. All controls are shadowed at
// frame start (h=0, v=0), so updates do not tear. The output pipeline is
// two stages deep: the pixel sampled at edge t appears after edge t+2.
// Optional build macro: DESENHA_SPRITE_BLINK_EN. When it is defined, the
// sprite blinks with a half-period of BLINK_FRAMES frames while blink=1.
// Ports:
//   clk, reset_n         : pixel clock, asynchronous active-low reset
//   h_counter, v_counter : beam position from the VGA timing generator
//   pos_x, pos_y         : glyph top-left corner
//   glyph_sel            : glyph_e code
//   scale                : integer scale (0 behaves as 1)
//   color                : {R,G,B} foreground
//   enable, blink        : visibility and blink request
//   hit, R, G, B         : foreground flag and pixel colour (black when no hit)
// -----------------------------------------------------------------------------
module desenha_sprite
    import desenha_pkg::*;
#(
    parameter int GLYPH_SIZE   = 8,
    parameter int SCALE_W      = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         h_counter,
    input  logic [9:0]         v_counter,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [1:0]         glyph_sel,
    input  logic [SCALE_W-1:0] scale,
    input  logic [COLOR_W-1:0] color,
    input  logic               enable,
    input  logic               blink,
    output logic               hit,
    output logic [7:0]         R,
    output logic [7:0]         G,
    output logic [7:0]         B
);

    localparam int IDX_W = $clog2(GLYPH_SIZE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(GLYPH_SIZE - 1);

    logic               w_frame_start;
    logic               w_line_start;
    logic [SCALE_W-1:0] w_scale_in;
    logic [9:0]         w_pos_x;
    logic [9:0]         w_pos_y;
    logic [SCALE_W-1:0] w_scale;

    logic [9:0]         r_sh_pos_x;
    logic [9:0]         r_sh_pos_y;
    glyph_e             r_sh_glyph;
    logic [SCALE_W-1:0] r_sh_scale;
    logic [COLOR_W-1:0] r_sh_color;
    logic               r_sh_enable;

    logic [IDX_W-1:0]   w_row;
    logic [IDX_W-1:0]   w_col;
    logic               w_row_act;
    logic               w_col_act;
    logic               w_visible;
    logic               w_pattern;

    logic               r_pix_on;
    logic               r_hit;
    logic [COLOR_W-1:0] r_rgb;

    assign w_frame_start = (h_counter == '0) && (v_counter == '0);
    assign w_line_start  = (h_counter == '0);
    assign w_scale_in    = (scale == '0) ? SCALE_W'(1) : scale;

    // On the frame-start edge the axes must already see the new values, so a
    // glyph at pos_y=0 (or pos_x=0) starts on the same edge it is latched.
    assign w_pos_x = w_frame_start ? pos_x      : r_sh_pos_x;
    assign w_pos_y = w_frame_start ? pos_y      : r_sh_pos_y;
    assign w_scale = w_frame_start ? w_scale_in : r_sh_scale;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_pos_x  <= '0;
            r_sh_pos_y  <= '0;
            r_sh_glyph  <= GLYPH_BLANK;
            r_sh_scale  <= SCALE_W'(1);
            r_sh_color  <= '0;
            r_sh_enable <= 1'b0;
        end else if (w_frame_start) begin
            r_sh_pos_x  <= pos_x;
            r_sh_pos_y  <= pos_y;
            r_sh_glyph  <= glyph_e'(glyph_sel);
            r_sh_scale  <= w_scale_in;
            r_sh_color  <= color;
            r_sh_enable <= enable;
        end
    end

    desenha_eixo #(
        .GLYPH_SIZE (GLYPH_SIZE),
        .SCALE_W    (SCALE_W),
        .CNT_W      (10),
        .IDX_W      (IDX_W)
    ) u_row (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_step    (w_line_start),
        .i_clear   (w_frame_start),
        .i_counter (v_counter),
        .i_start   (w_pos_y),
        .i_scale   (w_scale),
        .o_idx     (w_row),
        .o_act     (w_row_act)
    );

    desenha_eixo #(
        .GLYPH_SIZE (GLYPH_SIZE),
        .SCALE_W    (SCALE_W),
        .CNT_W      (10),
        .IDX_W      (IDX_W)
    ) u_col (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_step    (1'b1),
        .i_clear   (w_line_start),
        .i_counter (h_counter),
        .i_start   (w_pos_x),
        .i_scale   (w_scale),
        .o_idx     (w_col),
        .o_act     (w_col_act)
    );

`ifdef DESENHA_SPRITE_BLINK_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_phase;
    logic               r_sh_visible;

    // Visibility is shadowed from the phase before this frame's update, so
    // frames 0..BLINK_FRAMES-1 after reset are hidden, the next half-period shown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt  <= '0;
            r_phase      <= 1'b0;
            r_sh_visible <= 1'b0;
        end else if (w_frame_start) begin
            r_sh_visible <= !blink | r_phase;
            if (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_visible = r_sh_visible;
`else
    // Blink is not built in this configuration; its inputs are intentionally dead.
    logic w_unused_blink;
    assign w_unused_blink = blink & (BLINK_FRAMES > 0);
    assign w_visible      = 1'b1;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_pattern = 1'b0;
        case (r_sh_glyph)
            GLYPH_X:   w_pattern = (w_col == w_row) || (w_col == LAST - w_row);
            GLYPH_O:   w_pattern = ((w_row == '0 || w_row == LAST) && w_col != '0 && w_col != LAST) ||
                                   ((w_col == '0 || w_col == LAST) && w_row != '0 && w_row != LAST);
            GLYPH_BOX: w_pattern = (w_row == '0) || (w_row == LAST) || (w_col == '0) || (w_col == LAST);
            default:   w_pattern = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_on <= 1'b0;
            r_hit    <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_pix_on <= w_row_act & w_col_act & w_pattern & r_sh_enable & w_visible;
            r_hit    <= r_pix_on;
            r_rgb    <= r_pix_on ? r_sh_color : '0;
        end
    end

    assign hit       = r_hit;
    assign {R, G, B} = r_rgb;

endmodule

// File: tb/tb_desenha_sprite.sv
// -----------------------------------------------------------------------------
// tb_desenha_sprite
// Directed bench for desenha_sprite. Each pixel driven pushes the expected
// {hit,RGB} from a geometric reference model onto a scoreboard queue. The
// entry is popped and compared once the pipeline latency has elapsed. Build
// with DESENHA_SPRITE_BLINK_EN to exercise blinking (BLINK_FRAMES=2).
// -----------------------------------------------------------------------------
module tb_desenha_sprite;
    import desenha_pkg::*;

    localparam int GS = 8;
    localparam int SW = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    h_counter, v_counter, pos_x, pos_y;
    logic [1:0]    glyph_sel;
    logic [SW-1:0] scale;
    logic [23:0]   color;
    logic          enable, blink;
    logic          hit;
    logic [7:0]    R, G, B;

    desenha_sprite #(
        .GLYPH_SIZE   (GS),
        .SCALE_W      (SW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_counter (h_counter),
        .v_counter (v_counter),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .glyph_sel (glyph_sel),
        .scale     (scale),
        .color     (color),
        .enable    (enable),
        .blink     (blink),
        .hit       (hit),
        .R         (R),
        .G         (G),
        .B         (B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] exp;
        int          v;
        int          h;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state, latched at frame start like the DUT's shadows.
    int          m_px, m_py, m_scale, m_glyph, m_frame;
    logic        m_en, m_vis;
    logic [23:0] m_color;

    task automatic check(input string tag, input int v, input int h,
                         input logic [24:0] obs, input logic [24:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s v=%0d h=%0d got hit=%b rgb=%06h want hit=%b rgb=%06h",
                   tag, v, h, obs[24], obs[23:0], exp[24], exp[23:0]);
        end
    endtask

    function automatic logic pattern(input int g, input int r, input int c);
        int l = GS - 1;
        case (g)
            1:       return (c == r) || (c == l - r);
            2:       return ((r == 0 || r == l) && c >= 1 && c <= l - 1) ||
                            ((c == 0 || c == l) && r >= 1 && r <= l - 1);
            3:       return (r == 0) || (r == l) || (c == 0) || (c == l);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [24:0] model_pix(input int v, input int h);
        int sz;
        if (!m_en || !m_vis) return '0;
        sz = GS * m_scale;
        if (v < m_py || v >= m_py + sz || h < m_px || h >= m_px + sz) return '0;
        if (pattern(m_glyph, (v - m_py) / m_scale, (h - m_px) / m_scale))
            return {1'b1, m_color};
        return '0;
    endfunction

    task automatic latch_model();
        m_px    = int'(pos_x);
        m_py    = int'(pos_y);
        m_glyph = int'(glyph_sel);
        m_scale = (scale == '0) ? 1 : int'(scale);
        m_color = color;
        m_en    = enable;
`ifdef DESENHA_SPRITE_BLINK_EN
        m_vis   = !blink || (((m_frame / BF) % 2) == 1);
`else
        m_vis   = 1'b1;
`endif
        m_frame++;
    endtask

    // Drive one pixel, record its expectation, then retire anything whose
    // latency has elapsed. Returns 1 time unit after the sampling edge.
    task automatic drive_pix(input int v, input int h);
        exp_t e;
        v_counter = 10'(v);
        h_counter = 10'(h);
        if (v == 0 && h == 0) latch_model();
        e.exp = model_pix(v, h);
        e.v   = v;
        e.h   = h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > PIPE_LATENCY) begin
            e = sb.pop_front();
            check("pix", e.v, e.h, {hit, R, G, B}, e.exp);
        end
    endtask

    task automatic run_line(input int v, input int ha, input int hlo, input int hhi);
        for (int h = 0; h <= ha; h++) drive_pix(v, h);
        for (int h = hlo; h <= hhi; h++) drive_pix(v, h);
    endtask

    task automatic run_frame(input int vlo, input int vhi, input int ha,
                             input int hlo, input int hhi);
        run_line(0, ha, hlo, hhi);
        for (int v = vlo; v <= vhi; v++) run_line(v, ha, hlo, hhi);
    endtask

    task automatic set_sprite(input int x, input int y, input int g,
                              input int s, input logic [23:0] c);
        pos_x     = 10'(x);
        pos_y     = 10'(y);
        glyph_sel = 2'(g);
        scale     = SW'(s);
        color     = c;
    endtask

    initial begin
        m_en = 1'b0; m_vis = 1'b0; m_frame = 0;
        m_px = 0; m_py = 0; m_scale = 1; m_glyph = 0; m_color = '0;
        reset_n = 1'b0;
        enable  = 1'b1;
        blink   = 1'b0;
        set_sprite(100, 50, 1, 1, 24'hFF0000);
        v_counter = 10'd1;
        h_counter = 10'd1;

        // Reset held, then released mid-frame: dark until the first frame start.
        for (int i = 0; i < 4; i++) drive_pix(1, 1);
        reset_n = 1'b1;
        for (int v = 45; v <= 60; v++) run_line(v, 3, 96, 112);

        // X at (100,50), scale 1: diagonals on lines 50..57 only.
        run_frame(46, 60, 3, 96, 112);

        // O at (200,200), scale 3: 24x24 footprint, dark corners.
        set_sprite(200, 200, 2, 3, 24'h00FF00);
        run_frame(196, 228, 3, 196, 228);

        // Mid-frame move: the current frame keeps (10,10), the next uses (300,300).
        set_sprite(10, 10, 1, 1, 24'h0000FF);
        run_line(0, 25, 296, 312);
        for (int v = 1; v <= 20; v++) begin
            if (v == 5) begin
                pos_x = 10'd300;
                pos_y = 10'd300;
            end
            run_line(v, 25, 296, 312);
        end
        for (int v = 296; v <= 312; v++) run_line(v, 25, 296, 312);
        run_frame(1, 20, 25, 296, 312);
        for (int v = 296; v <= 312; v++) run_line(v, 25, 296, 312);

        // Box at x=630, scale 2: clipped at h=639, nothing wraps to h=0..7.
        set_sprite(630, 20, 3, 2, 24'h123456);
        run_frame(18, 38, 7, 626, 639);

        // Scale 0 must draw exactly like scale 1.
        set_sprite(100, 50, 1, 0, 24'hFF0000);
        run_frame(46, 60, 3, 96, 112);

        // Reset while a lit pixel is on the outputs: they drop at once.
        scale = SW'(1);
        run_frame(46, 49, 3, 96, 112);
        for (int h = 0; h <= 3; h++) drive_pix(50, h);
        for (int h = 96; h <= 102; h++) drive_pix(50, h);
        reset_n = 1'b0;
        #1;
        check("reset_mid", 50, 102, {hit, R, G, B}, 25'd0);
        sb.delete();
        m_en = 1'b0; m_vis = 1'b0; m_frame = 0;
        for (int i = 0; i < 3; i++) drive_pix(1, 1);
        reset_n = 1'b1;

        // Blink request over six frames after reset.
        blink = 1'b1;
        for (int f = 0; f < 6; f++) run_frame(46, 60, 3, 96, 112);

        // Drain the pipeline with dark pixels.
        for (int i = 0; i < PIPE_LATENCY + 1; i++) drive_pix(1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/desenha_sprite.md
Name: desenha_sprite

Overview:
Parametrised successor to the single-pattern X drawer. Renders one of four procedurally generated glyphs (blank, X, O, box) at a runtime position, runtime integer scale and runtime 24-bit colour. Scaling uses incremental per-axis counters, not division. Register shadowing at frame start gives tear-free updates. Sits between the VGA timing generator and the pixel mixer, one instance per board sprite; the mixer composites on `hit`.

Parameters:
GLYPH_SIZE, 8, glyph edge in source pixels (4..16)
SCALE_W, 4, width of scale input; max scale 2^SCALE_W-1
BLINK_FRAMES, 30, frames per blink half-period (used only with DESENHA_SPRITE_BLINK_EN)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
h_counter  in  10  horizontal pixel counter; 0 marks line start
v_counter  in  10  vertical line counter; h=0,v=0 marks frame start
pos_x  in  10  glyph top-left X
pos_y  in  10  glyph top-left Y
glyph_sel  in  2  0=blank, 1=X, 2=O, 3=box
scale  in  SCALE_W  integer scale; 0 treated as 1
color  in  24  {R,G,B} foreground colour
enable  in  1  sprite visible
blink  in  1  request blinking (ignored without macro)
hit  out  1  foreground pixel present
R  out  8  red
G  out  8  green
B  out  8  blue

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0: R, G, B = 0, hit = 0, all counters = 0, latched enable = 0. After release, nothing is drawn until the first frame start.
- Frame start (h_counter=0 and v_counter=0, sampled on clk): pos_x, pos_y, glyph_sel, scale (0 becomes 1), color, enable and blink are copied into shadow registers. Changes mid-frame have no effect until the next frame start.
- Row axis, updated at each h_counter=0:
  - If v_counter = sh_pos_y: row=0, row_sub=0, row_act=1.
  - Else if row_act: row_sub increments. When row_sub = scale-1, row_sub=0 and row increments. When row = GLYPH_SIZE-1 and row_sub = scale-1, row_act=0.
- Column axis, updated every cycle:
  - At h_counter=0: col_act is cleared.
  - If h_counter = sh_pos_x: col=0, sub=0, col_act=1.
  - Else if col_act: advances with the same rule as the row axis, ending after GLYPH_SIZE*scale pixels.
- Clipping: counters are never wrapped. A glyph running past the line or frame end is truncated, never wrapped to the opposite edge.
- Pattern bit, with N = GLYPH_SIZE:
  - X: col=row or col=N-1-row.
  - O: (row∈{0,N-1} and 1≤col≤N-2) or (col∈{0,N-1} and 1≤row≤N-2).
  - Box: row∈{0,N-1} or col∈{0,N-1}.
  - Blank: never.
- Pipeline:
  - Stage 1 registers pix_on = row_act & col_act & pattern & sh_enable & visible.
  - Stage 2 registers the outputs: hit=pix_on; {R,G,B} = pix_on ? sh_color : 0.
  - Latency: the output for the pixel whose h_counter is presented at edge t appears after edge t+2. This is fixed and documented for the mixer.
- Simultaneous events: frame start and row start coinciding (pos_y=0) are both handled on the same edge. Row logic uses the newly latched values.
- Reset mid-frame: outputs go to 0 immediately. Drawing resumes at the next frame start.

Optional Feature:
DESENHA_SPRITE_BLINK_EN
- Defined:
  - A frame counter counts 0..BLINK_FRAMES-1 at each frame start; on wrap, `phase` toggles.
  - visible = !sh_blink | phase.
  - Counter and phase reset to 0, so a blinking sprite is hidden for the first BLINK_FRAMES frames after reset.
- Undefined: visible=1 always; the blink port is ignored and no counter is built.

Decomposition:
- Package desenha_pkg:
  - glyph code constants: GLYPH_BLANK=0, GLYPH_X=1, GLYPH_O=2, GLYPH_BOX=3
  - colour width constant (24)
  - pipeline latency constant (2)
- Sub-module desenha_eixo: one axis counter (start-match, sub/idx counters, active flag, scale input). Instantiated twice, for rows and columns.
- Pattern function and output pipeline stay in the top module.

Test Plan:
1. Reset release, enable=1, glyph=X, pos=(100,50), scale=1, color=FF0000, before the first frame start → hit=0 and RGB=0 for the whole partial frame.
2. X, pos=(100,50), scale=1 → on line 50, hit=1 two cycles after h=100 and two cycles after h=107; h=101..106 dark. Line 51 lit at h=101 and h=106. R=FF, G=B=0. Nothing drawn on lines <50 or >57.
3. O, scale=3, pos=(200,200) → glyph occupies h 200..223 and v 200..223. Corner 3×3 blocks are dark; pixel (203,200) is lit. Each source row is repeated on exactly 3 lines.
4. pos changed mid-frame from (10,10) to (300,300) at v=5 → current frame draws at (10,10); next frame draws at (300,300).
5. pos_x=630, box, scale=2 → pixels 630..639 lit on the top row, none at h=0..5 (no wrap). scale=0 behaves exactly as scale=1.
6. With DESENHA_SPRITE_BLINK_EN and BLINK_FRAMES=2, blink=1 → hidden in frames 0–1, visible in frames 2–3, hidden in frames 4–5. Without the macro, visible in every frame.
